// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx_arbiter                                                 |
// | Function : round-robin arbiter sharing one UART transmit line              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic [15:0]               baud_div,
  input  logic                      parity_en,
  input  logic                      parity_odd,
  input  logic                      two_stop,
  output logic                      Tx,
  output logic                      busy,
  output logic [2:0]                owner
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_PARITY = 3'd3;
  localparam logic [2:0] c_STOP   = 3'd4;

  localparam int              c_BW   = $clog2(DATA_W);
  localparam logic [c_BW-1:0] c_LAST = c_BW'(DATA_W - 1);

  logic [2:0]        r_state;
  logic [15:0]       r_cnt;
  logic [15:0]       r_bd;
  logic [DATA_W-1:0] r_shift;
  logic [c_BW-1:0]   r_bit;
  logic              r_par;
  logic              r_pen;
  logic              r_two;
  logic [2:0]        r_ptr;

  logic [2:0]        w_state_nx;
  logic [15:0]       w_cnt_nx;
  logic [DATA_W-1:0] w_shift_nx;
  logic [c_BW-1:0]   w_bit_nx;
  logic              w_tx_nx;
  logic              w_busy_nx;
  logic [NUM_REQ-1:0] w_gnt_nx;
  logic [NUM_REQ-1:0] w_rot;
  logic              w_found;
  logic [2:0]        w_off;
  logic [3:0]        w_sum;
  logic [2:0]        w_sel;
  logic [2:0]        w_ptr_nx;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_grant;
  logic              w_bit_end;

  // Rotate requests so the highest-priority requester sits at bit 0.
  assign w_rot = NUM_REQ'({req, req} >> r_ptr);

  always_comb begin
    w_found = 1'b0;
    w_off   = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_off   = 3'(i);
      end
    end
  end

  assign w_sum    = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_sel    = (w_sum >= 4'(NUM_REQ)) ? 3'(w_sum - 4'(NUM_REQ)) : 3'(w_sum);
  assign w_ptr_nx = (w_sel == 3'(NUM_REQ - 1)) ? 3'd0 : w_sel + 3'd1;
  assign w_grant  = (r_state == c_IDLE) && w_found;
  assign w_bit_end = (r_cnt == r_bd);

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel == 3'(i)) w_sel_data = data[i*DATA_W +: DATA_W];
    end
  end

  // State register and datapath; outputs are registered from next-cycle values.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_bd    <= '0;
      r_shift <= '0;
      r_bit   <= '0;
      r_par   <= 1'b0;
      r_pen   <= 1'b0;
      r_two   <= 1'b0;
      r_ptr   <= 3'd0;
      owner   <= 3'd0;
      gnt     <= '0;
      Tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_shift <= w_shift_nx;
      r_bit   <= w_bit_nx;
      gnt     <= w_gnt_nx;
      Tx      <= w_tx_nx;
      busy    <= w_busy_nx;
      if (w_grant) begin
        r_bd  <= baud_div;
        r_pen <= parity_en;
        r_two <= two_stop;
        r_par <= (^w_sel_data) ^ parity_odd;
        owner <= w_sel;
        r_ptr <= w_ptr_nx;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_shift_nx = r_shift;
    w_bit_nx   = r_bit;
    if (r_state != c_IDLE) w_cnt_nx = w_bit_end ? 16'd0 : r_cnt + 16'd1;
    case (r_state)
      c_IDLE: begin
        if (w_grant) begin
          w_state_nx = c_START;
          w_cnt_nx   = 16'd0;
          w_bit_nx   = '0;
          w_shift_nx = w_sel_data;
        end
      end
      c_START: begin
        if (w_bit_end) w_state_nx = c_DATA;
      end
      c_DATA: begin
        if (w_bit_end) begin
          w_shift_nx = r_shift >> 1;
          w_bit_nx   = r_bit + c_BW'(1);
          if (r_bit == c_LAST) begin
            w_bit_nx   = '0;
            w_state_nx = r_pen ? c_PARITY : c_STOP;
          end
        end
      end
      c_PARITY: begin
        if (w_bit_end) w_state_nx = c_STOP;
      end
      c_STOP: begin
        // r_bit doubles as the stop-bit index here.
        if (w_bit_end) begin
          if (r_two && (r_bit == '0)) w_bit_nx = c_BW'(1);
          else                        w_state_nx = c_IDLE;
        end
      end
      default: w_state_nx = c_IDLE;
    endcase
  end

  always_comb begin
    w_tx_nx   = 1'b1;
    w_busy_nx = (w_state_nx != c_IDLE);
    w_gnt_nx  = '0;
    case (w_state_nx)
      c_START:  w_tx_nx = 1'b0;
      c_DATA:   w_tx_nx = w_shift_nx[0];
      c_PARITY: w_tx_nx = r_par;
      default:  w_tx_nx = 1'b1;
    endcase
    for (int i = 0; i < NUM_REQ; i++) begin
      w_gnt_nx[i] = w_grant && (w_sel == 3'(i));
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART serial transmit line among NUM_REQ byte producers, for example the APB register path, a loopback/echo path and a debug port.
- Arbitrates round-robin and serialises each granted byte as a standard UART frame on Tx: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits.
- Per-frame timing and format are sampled from configuration inputs at grant time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, data bits per frame (fixed at 8 for this release).

Ports:
- PCLK  input  1  system clock.
- PRESET  input  1  reset; asynchronous and active-high.
- req  input  NUM_REQ  per-requester send request; held high with data stable until granted.
- data  input  NUM_REQ*DATA_W  flattened bytes; requester i occupies bits [i*8+7:i*8].
- gnt  output  NUM_REQ  one-hot, one-cycle pulse; marks acceptance of that requester's byte.
- baud_div  input  16  bit period = baud_div+1 PCLK cycles.
- parity_en  input  1  when 1, a parity bit follows the data bits.
- parity_odd  input  1  when 1, odd parity; when 0, even parity.
- two_stop  input  1  when 1, two stop bits; when 0, one.
- Tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is being sent.
- owner  output  3  index of the current or last granted requester.

Behaviour:
- Reset values (asynchronous, immediate on PRESET): Tx=1, gnt=0, busy=0, owner=0. State=IDLE. The round-robin pointer is set so requester 0 has highest priority on the first grant.
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE:
  - Tx=1, busy=0.
  - If any req is high at a rising edge, at that same edge:
    - Select the first high req at or after pointer, wrapping modulo NUM_REQ.
    - Pulse gnt[sel] for one cycle and latch data[sel].
    - Latch baud_div, parity_en, parity_odd and two_stop.
    - Set owner=sel and pointer=sel+1 (wrapping).
    - Enter START; Tx=0 and busy=1 in the same cycle gnt is high.
  - Latency: req sampled at edge N gives gnt, Tx=0 and busy=1 during cycle N..N+1.
- Bit timer: counts 0..baud_div_latched. Each bit is driven for exactly baud_div_latched+1 cycles; baud_div=0 means one cycle per bit.
- START: Tx=0 for one bit period, then DATA.
- DATA:
  - Tx=shift[0], LSB first; shift right after each bit.
  - After 8 bits, go to PARITY if parity_en_latched, else STOP.
- PARITY: Tx = XOR of the 8 latched bits, XOR parity_odd_latched. One bit period, then STOP.
- STOP: Tx=1 for 1 or 2 bit periods. At the last cycle of the final stop bit, go to IDLE; busy drops on that transition.
- Frame length: (1+8+p+s)*(baud_div+1) cycles, where p ∈ {0,1} and s ∈ {1,2}.
- Back-to-back frames: a req held high at the first IDLE edge is granted immediately, so the line idles exactly one cycle (Tx=1) between frames.
- Req with no grant: if req drops before being granted, it is never granted and nothing is sent. Requesters must not drop req while waiting.
- Config during a frame: changes to baud_div or the format inputs have no effect on the frame in flight.
- Requests during a frame: req changes are ignored until IDLE.
- Simultaneous requests: exactly one grant per frame. No requester waits more than NUM_REQ-1 frames while continuously requesting.
- Reset mid-frame: frame aborted, Tx=1 at once; no gnt is issued after reset until a new IDLE arbitration.

Test Plan:
- Single byte: req[0]=1, data0=0xA5, baud_div=3, no parity, 1 stop -> gnt[0] single pulse. Tx per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1. busy high for 40 cycles. owner=0.
- Round-robin: req=4'b1111 held, each req dropped one cycle after its gnt and re-raised -> grant order 0,1,2,3,0. One idle-high cycle between frames.
- Parity: data=0x07, parity_en=1. With parity_odd=0 the parity bit is 1; with parity_odd=1 it is 0. two_stop=1 gives two high stop periods. Frame length is 12*(baud_div+1) cycles.
- Minimum divisor: baud_div=0, data=0xFF -> Tx=0 for one cycle, then ten 1s (8 data + 1 stop + idle). busy high for 10 cycles.
- Config change mid-frame: baud_div switched 3->7 during DATA -> current frame keeps 4-cycle bits; next frame uses 8-cycle bits.
- Reset mid-frame: PRESET pulsed during DATA bit 4 -> Tx=1, busy=0 immediately. A pending req[2] is granted at the first edge after reset release. With all requesters high, req[0] wins first after reset.
